// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read-channel arbiter (instruction fetch = 0, data = 1).
// Round-robin grant, one burst outstanding, AR fields latched at grant and
// R channel steered back to the granted requester only.
module axi_rd_arbiter #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // requester side
   input  logic [1:0]            m_arvalid,
   output logic [1:0]            m_arready,
   input  logic [2*ADDR_W-1:0]   m_araddr,
   input  logic [15:0]           m_arlen,
   input  logic [5:0]            m_arsize,
   input  logic [3:0]            m_arburst,
   output logic [1:0]            m_rvalid,
   input  logic [1:0]            m_rready,
   output logic [DATA_W-1:0]     m_rdata,
   output logic [1:0]            m_rresp,
   output logic                  m_rlast,
   // shared interconnect side
   output logic                  s_arvalid,
   input  logic                  s_arready,
   output logic [ADDR_W-1:0]     s_araddr,
   output logic [7:0]            s_arlen,
   output logic [2:0]            s_arsize,
   output logic [1:0]            s_arburst,
   output logic [3:0]            s_arid,
   input  logic                  s_rvalid,
   output logic                  s_rready,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic [1:0]            s_rresp,
   input  logic                  s_rlast
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t              state;
   logic                gnt;
   logic                last_gnt;
   logic                pick;
   logic [ADDR_W-1:0]   sel_addr;
   logic [7:0]          sel_len;
   logic [2:0]          sel_size;
   logic [1:0]          sel_burst;

   // Round-robin choice: the requester that was not served last wins a tie
   always_comb begin
      pick = 1'b0;
      case (m_arvalid)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_gnt;
         default: pick = 1'b0;
      endcase
   end

   // AR field mux for the requester about to be granted
   always_comb begin
      sel_addr  = pick ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
      sel_len   = pick ? m_arlen[15:8]   : m_arlen[7:0];
      sel_size  = pick ? m_arsize[5:3]   : m_arsize[2:0];
      sel_burst = pick ? m_arburst[3:2]  : m_arburst[1:0];
   end

   // Grant strobe in IDLE; gated by rst_n so it stays low throughout reset
   always_comb begin
      m_arready = '0;
      if (rst_n && state == IDLE && |m_arvalid)
         m_arready[pick] = 1'b1;
   end

   // R channel steering toward the granted requester during DATA only
   always_comb begin
      m_rvalid = '0;
      s_rready = 1'b0;
      if (state == DATA) begin
         m_rvalid[gnt] = s_rvalid;
         s_rready      = m_rready[gnt];
      end
   end

   // Shared AR drive and broadcast R payload
   always_comb begin
      s_arvalid = (state == ADDR);
      s_arid    = {3'b000, gnt};
      m_rdata   = s_rdata;
      m_rresp   = s_rresp;
      m_rlast   = s_rlast;
   end

   // Arbitration FSM: grant/latch, address handshake, data until rlast
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= 1'b0;
         last_gnt  <= 1'b1;
         s_araddr  <= '0;
         s_arlen   <= '0;
         s_arsize  <= '0;
         s_arburst <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|m_arvalid) begin
                  gnt       <= pick;
                  s_araddr  <= sel_addr;
                  s_arlen   <= sel_len;
                  s_arsize  <= sel_size;
                  s_arburst <= sel_burst;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (s_arready)
                  state <= DATA;
            end
            DATA: begin
               if (s_rvalid && m_rready[gnt] && s_rlast) begin
                  last_gnt <= gnt;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;

   logic          clk;
   logic          rst_n;
   logic [1:0]    m_arvalid;
   logic [1:0]    m_arready;
   logic [127:0]  m_araddr;
   logic [15:0]   m_arlen;
   logic [5:0]    m_arsize;
   logic [3:0]    m_arburst;
   logic [1:0]    m_rvalid;
   logic [1:0]    m_rready;
   logic [63:0]   m_rdata;
   logic [1:0]    m_rresp;
   logic          m_rlast;
   logic          s_arvalid;
   logic          s_arready;
   logic [63:0]   s_araddr;
   logic [7:0]    s_arlen;
   logic [2:0]    s_arsize;
   logic [1:0]    s_arburst;
   logic [3:0]    s_arid;
   logic          s_rvalid;
   logic          s_rready;
   logic [63:0]   s_rdata;
   logic [1:0]    s_rresp;
   logic          s_rlast;

   int errors = 0;
   int checks = 0;

   axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_araddr  (m_araddr),
      .m_arlen   (m_arlen),
      .m_arsize  (m_arsize),
      .m_arburst (m_arburst),
      .m_rvalid  (m_rvalid),
      .m_rready  (m_rready),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rlast   (m_rlast),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .s_araddr  (s_araddr),
      .s_arlen   (s_arlen),
      .s_arsize  (s_arsize),
      .s_arburst (s_arburst),
      .s_arid    (s_arid),
      .s_rvalid  (s_rvalid),
      .s_rready  (s_rready),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rlast   (s_rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle-state request; verifies the same-cycle grant strobe, then clocks it in
   task automatic request(input logic [1:0] v, input logic [1:0] exp_rdy, input string tag);
      m_arvalid = v;
      #1;
      check({tag, "_arready"}, m_arready, exp_rdy);
      tick();
      m_arvalid = 2'b00;
   endtask

   // Address phase: latched fields presented, then accepted by the interconnect
   task automatic addr_phase(input logic [63:0] exp_addr, input logic [3:0] exp_id,
                             input logic [7:0] exp_len, input string tag);
      check({tag, "_arvalid"}, s_arvalid, 1'b1);
      check({tag, "_araddr"}, s_araddr, exp_addr);
      check({tag, "_arid"}, s_arid, exp_id);
      check({tag, "_arlen"}, s_arlen, exp_len);
      check({tag, "_arready_addr"}, m_arready, 2'b00);
      s_arready = 1'b1;
      tick();
      s_arready = 1'b0;
      check({tag, "_arvalid_data"}, s_arvalid, 1'b0);
   endtask

   // One accepted R beat; caller sets m_rready
   task automatic beat(input logic [63:0] d, input logic [1:0] resp, input logic last,
                       input logic [1:0] exp_rv, input string tag);
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rresp  = resp;
      s_rlast  = last;
      #1;
      check({tag, "_rvalid"}, m_rvalid, exp_rv);
      check({tag, "_rready"}, s_rready, 1'b1);
      check({tag, "_rdata"}, m_rdata, d);
      check({tag, "_rresp"}, m_rresp, resp);
      check({tag, "_rlast"}, m_rlast, last);
      tick();
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      m_arvalid = 2'b11;
      m_araddr  = '0;
      m_arlen   = '0;
      m_arsize  = '0;
      m_arburst = '0;
      m_rready  = '0;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      s_rdata   = '0;
      s_rresp   = '0;
      s_rlast   = 1'b0;

      // Reset state, with requests and R traffic present but held off
      tick();
      s_rvalid = 1'b1;
      m_rready = 2'b11;
      tick();
      check("rst_arready", m_arready, 2'b00);
      check("rst_arvalid", s_arvalid, 1'b0);
      check("rst_srready", s_rready, 1'b0);
      check("rst_mrvalid", m_rvalid, 2'b00);
      check("rst_araddr", s_araddr, 64'h0);
      check("rst_arid", s_arid, 4'h0);
      m_arvalid = 2'b00;
      s_rvalid  = 1'b0;
      m_rready  = 2'b00;
      #2;
      rst_n = 1'b1;
      tick();

      // Single-beat fetch from requester 0
      m_araddr[63:0] = 64'h8000_0000;
      m_arlen[7:0]   = 8'd0;
      m_arsize[2:0]  = 3'd3;
      m_arburst[1:0] = 2'b01;
      request(2'b01, 2'b01, "t1");
      check("t1_arsize", s_arsize, 3'd3);
      check("t1_arburst", s_arburst, 2'b01);
      addr_phase(64'h8000_0000, 4'h0, 8'd0, "t1");
      m_rready = 2'b01;
      beat(64'h1111_2222_3333_4444, 2'b00, 1'b1, 2'b01, "t1b0");
      // Back in IDLE: stray s_rvalid must not be forwarded
      s_rvalid = 1'b1;
      #1;
      check("t1_idle_mrvalid", m_rvalid, 2'b00);
      check("t1_idle_srready", s_rready, 1'b0);
      check("t1_idle_arvalid", s_arvalid, 1'b0);
      s_rvalid = 1'b0;
      m_rready = 2'b00;

      // Contention out of reset: 0 first, then 1 at the cycle after rlast
      reset_pulse();
      m_araddr = {64'hB000_0100, 64'hA000_0000};
      m_arlen  = 16'h0000;
      m_arvalid = 2'b11;
      #1;
      check("t2_first_gnt", m_arready, 2'b01);
      tick();
      check("t2_addr_mready", m_arready, 2'b00);
      addr_phase(64'hA000_0000, 4'h0, 8'd0, "t2a");
      m_rready = 2'b11;
      beat(64'hAAAA, 2'b00, 1'b1, 2'b01, "t2a_b0");
      check("t2_second_gnt", m_arready, 2'b10);
      tick();
      m_arvalid = 2'b00;
      addr_phase(64'hB000_0100, 4'h1, 8'd0, "t2b");
      beat(64'hBBBB, 2'b00, 1'b1, 2'b10, "t2b_b0");

      // Requester 1 four-beat burst with two back-pressure cycles
      m_araddr[127:64] = 64'hC000_2000;
      m_arlen[15:8]    = 8'd3;
      request(2'b10, 2'b10, "t3");
      addr_phase(64'hC000_2000, 4'h1, 8'd3, "t3");
      m_rready = 2'b10;
      beat(64'hD0, 2'b00, 1'b0, 2'b10, "t3b0");
      for (int i = 0; i < 2; i++) begin
         m_rready = 2'b01;
         s_rvalid = 1'b1;
         s_rdata  = 64'hD1;
         #1;
         check("t3_stall_srready", s_rready, 1'b0);
         check("t3_stall_mrvalid", m_rvalid, 2'b10);
         tick();
      end
      m_rready = 2'b10;
      beat(64'hD1, 2'b00, 1'b0, 2'b10, "t3b1");
      beat(64'hD2, 2'b00, 1'b0, 2'b10, "t3b2");
      beat(64'hD3, 2'b00, 1'b1, 2'b10, "t3b3");
      check("t3_done_arvalid", s_arvalid, 1'b0);

      // Address stall; requester 0 toggles its request, then an error beat
      m_araddr[63:0] = 64'hE000_0040;
      m_arlen[7:0]   = 8'd1;
      request(2'b01, 2'b01, "t4");
      for (int i = 0; i < 5; i++) begin
         m_arvalid[0]   = i[0];
         m_araddr[63:0] = 64'hDEAD_0000 + 64'(i);
         #1;
         check("t4_stall_arvalid", s_arvalid, 1'b1);
         check("t4_stall_araddr", s_araddr, 64'hE000_0040);
         check("t4_stall_arready", m_arready, 2'b00);
         tick();
      end
      m_arvalid = 2'b00;
      addr_phase(64'hE000_0040, 4'h0, 8'd1, "t4");
      m_rready = 2'b01;
      beat(64'hE0, 2'b00, 1'b0, 2'b01, "t4b0");
      beat(64'hE1, 2'b10, 1'b1, 2'b01, "t4b1");
      check("t4_done_arvalid", s_arvalid, 1'b0);

      // Reset during beat 2 of a four-beat burst
      m_araddr[127:64] = 64'hF000_0000;
      m_arlen[15:8]    = 8'd3;
      request(2'b10, 2'b10, "t5");
      addr_phase(64'hF000_0000, 4'h1, 8'd3, "t5");
      m_rready = 2'b10;
      beat(64'hF0, 2'b00, 1'b0, 2'b10, "t5b0");
      s_rvalid = 1'b1;
      s_rdata  = 64'hF1;
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_rst_mrvalid", m_rvalid, 2'b00);
      check("t5_rst_srready", s_rready, 1'b0);
      check("t5_rst_arvalid", s_arvalid, 1'b0);
      check("t5_rst_araddr", s_araddr, 64'h0);
      check("t5_rst_arid", s_arid, 4'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      m_rready = 2'b11;
      s_rlast  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_post_mrvalid", m_rvalid, 2'b00);
         check("t5_post_srready", s_rready, 1'b0);
         check("t5_post_arvalid", s_arvalid, 1'b0);
      end
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
      m_arvalid = 2'b11;
      #1;
      check("t5_regrant", m_arready, 2'b01);
      m_arvalid = 2'b00;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
